// File: rtl/mux_scan.sv
// Registered N-channel, W-bit selector with enable, manual select and an auto-scan mode
// that rotates through the channels, holding each for DWELL cycles.
module mux_scan #(
   parameter int unsigned W     = 2,
   parameter int unsigned N     = 4,
   parameter int unsigned SW    = $clog2(N),
   parameter int unsigned DWELL = 4
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic [N*W-1:0]  DIN,
   input  logic [SW-1:0]   S,
   input  logic            EN,
   input  logic            MODE,
   output logic [W-1:0]    Y,
   output logic [SW-1:0]   CH,
   output logic            VLD,
   output logic            WRAP
);

   localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] CntLast = CW'(DWELL - 1);
   localparam logic [SW-1:0] ChLast  = SW'(N - 1);
   localparam logic [SW:0]   NChan   = (SW + 1)'(N);

   typedef enum logic [1:0] {StIdle, StManual, StScan} state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    y_q, y_d;
   logic [SW-1:0]   ch_q, ch_d;
   logic            vld_q, vld_d;
   logic            wrap_q, wrap_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   cnt_cur;

   function automatic logic [W-1:0] pick(input logic [N*W-1:0] din, input logic [SW-1:0] idx);
      logic [W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (idx == SW'(i)) r = din[i*W +: W];
      end
      return r;
   endfunction

   always_comb begin
      state_d = StIdle;
      y_d     = '0;
      ch_d    = ch_q;
      vld_d   = 1'b0;
      wrap_d  = 1'b0;
      cnt_d   = '0;
      cnt_cur = '0;
      if (EN) state_d = MODE ? StScan : StManual;

      case (state_d)
         StManual: begin
            // Out-of-range selects only exist when N is not a power of two.
            if ({1'b0, S} < NChan) begin
               ch_d  = S;
               y_d   = pick(DIN, S);
               vld_d = 1'b1;
            end
         end
         StScan: begin
            // A fresh scan always starts its dwell from zero on the held channel.
            cnt_cur = (state_q == StScan) ? cnt_q : '0;
            if (cnt_cur == CntLast) begin
               cnt_d  = '0;
               ch_d   = (ch_q == ChLast) ? '0 : ch_q + 1'b1;
               wrap_d = (ch_q == ChLast);
            end else begin
               cnt_d = cnt_cur + 1'b1;
            end
            y_d   = pick(DIN, ch_d);
            vld_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= StIdle;
         y_q     <= '0;
         ch_q    <= '0;
         vld_q   <= 1'b0;
         wrap_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         ch_q    <= ch_d;
         vld_q   <= vld_d;
         wrap_q  <= wrap_d;
         cnt_q   <= cnt_d;
      end
   end

   assign Y    = y_q;
   assign CH   = ch_q;
   assign VLD  = vld_q;
   assign WRAP = wrap_q;

endmodule

// File: tb/tb_mux_scan.sv
// Directed bench for mux_scan: a 4-channel instance and a 3-channel instance, both DWELL=4.
module tb_mux_scan;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] din;
   logic [1:0] s;
   logic       en, mode;
   logic [1:0] y, ch;
   logic       vld, wrap;

   logic [5:0] din3;
   logic [1:0] s3;
   logic       en3, mode3;
   logic [1:0] y3, ch3;
   logic       vld3, wrap3;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mux_scan #(.W(2), .N(4), .DWELL(4)) dut4 (
      .CLK(clk), .RST_N(rst_n), .DIN(din), .S(s), .EN(en), .MODE(mode),
      .Y(y), .CH(ch), .VLD(vld), .WRAP(wrap)
   );

   mux_scan #(.W(2), .N(3), .DWELL(4)) dut3 (
      .CLK(clk), .RST_N(rst_n), .DIN(din3), .S(s3), .EN(en3), .MODE(mode3),
      .Y(y3), .CH(ch3), .VLD(vld3), .WRAP(wrap3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Observed vectors below are {Y, CH, VLD, WRAP}.
   task automatic test_reset();
      din = 8'b11_10_01_00; en = 1'b1; mode = 1'b1; s = 2'd0;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if ({y, ch, vld, wrap} !== 6'b00_00_0_0) begin
            $display("FAIL reset cyc%0d: got %b want 000000", i, {y, ch, vld, wrap});
            n_fail++;
         end
      end
      rst_n = 1'b1;
      tick();
      n_tests++;
      if ({y, ch, vld, wrap} !== 6'b00_00_1_0) begin
         $display("FAIL reset_release: got %b want 000010", {y, ch, vld, wrap});
         n_fail++;
      end
   endtask

   task automatic test_manual();
      logic [1:0] e;
      en = 1'b1; mode = 1'b0;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         e = 2'(k);
         s = e;
         tick();
         n_tests++;
         if ({y, ch, vld, wrap} !== {e, e, 1'b1, 1'b0}) begin
            $display("FAIL manual s=%0d: got %b want %b", k, {y, ch, vld, wrap}, {e, e, 2'b10});
            n_fail++;
         end
         repeat (9) tick();
      end
      en = 1'b0;
      tick();
      n_tests++;
      if ({y, ch, vld, wrap} !== 6'b00_11_0_0) begin
         $display("FAIL manual_disable: got %b want 001100", {y, ch, vld, wrap});
         n_fail++;
      end
   endtask

   task automatic test_scan();
      logic [1:0] e;
      logic       w;
      en = 1'b1; mode = 1'b1;
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         tick();
         e = 2'((k / 4) % 4);
         w = (k == 16);
         n_tests++;
         if ({y, ch, vld, wrap} !== {e, e, 1'b1, w}) begin
            $display("FAIL scan edge%0d: got %b want %b", k, {y, ch, vld, wrap}, {e, e, 1'b1, w});
            n_fail++;
         end
      end
   endtask

   task automatic test_live();
      logic [1:0] e;
      en = 1'b1; mode = 1'b1;
      do_reset();
      repeat (8) tick();
      din[5:4] = 2'b01;
      for (int k = 9; k <= 12; k++) begin
         tick();
         e = (k < 12) ? 2'b01 : 2'b11;
         n_tests++;
         if ({y, ch, vld} !== {e, 2'((k / 4) % 4), 1'b1}) begin
            $display("FAIL live edge%0d: got %b want %b", k, {y, ch, vld},
                     {e, 2'((k / 4) % 4), 1'b1});
            n_fail++;
         end
      end
      din[5:4] = 2'b10;
   endtask

   task automatic test_mode_switch();
      en = 1'b1; mode = 1'b1;
      do_reset();
      repeat (5) tick();
      mode = 1'b0; s = 2'd3;
      tick();
      n_tests++;
      if ({y, ch, vld, wrap} !== 6'b11_11_1_0) begin
         $display("FAIL mode_to_manual: got %b want 111110", {y, ch, vld, wrap});
         n_fail++;
      end
      mode = 1'b1;
      for (int j = 1; j <= 4; j++) begin
         tick();
         n_tests++;
         if ({y, ch, vld, wrap} !== ((j < 4) ? 6'b11_11_1_0 : 6'b00_00_1_1)) begin
            $display("FAIL mode_to_scan j%0d: got %b want %b", j, {y, ch, vld, wrap},
                     (j < 4) ? 6'b11_11_1_0 : 6'b00_00_1_1);
            n_fail++;
         end
      end
   endtask

   task automatic test_idle_resume();
      en = 1'b1; mode = 1'b1;
      do_reset();
      repeat (5) tick();
      en = 1'b0;
      repeat (2) begin
         tick();
         n_tests++;
         if ({y, ch, vld, wrap} !== 6'b00_01_0_0) begin
            $display("FAIL idle_hold: got %b want 000100", {y, ch, vld, wrap});
            n_fail++;
         end
      end
      en = 1'b1;
      for (int j = 1; j <= 4; j++) begin
         tick();
         n_tests++;
         if ({y, ch, vld} !== ((j < 4) ? 5'b01_01_1 : 5'b10_10_1)) begin
            $display("FAIL resume j%0d: got %b want %b", j, {y, ch, vld},
                     (j < 4) ? 5'b01_01_1 : 5'b10_10_1);
            n_fail++;
         end
      end
   endtask

   task automatic test_non_pow2();
      logic [1:0] e;
      logic       w;
      din3 = 6'b10_01_00; en3 = 1'b1; mode3 = 1'b0; s3 = 2'd2;
      do_reset();
      tick();
      n_tests++;
      if ({y3, ch3, vld3, wrap3} !== 6'b10_10_1_0) begin
         $display("FAIL np2_manual: got %b want 101010", {y3, ch3, vld3, wrap3});
         n_fail++;
      end
      s3 = 2'd3;
      tick();
      n_tests++;
      if ({y3, ch3, vld3, wrap3} !== 6'b00_10_0_0) begin
         $display("FAIL np2_oob: got %b want 001000", {y3, ch3, vld3, wrap3});
         n_fail++;
      end
      mode3 = 1'b1;
      for (int j = 1; j <= 16; j++) begin
         tick();
         e = (j < 4) ? 2'd2 : 2'(((j - 4) / 4) % 3);
         w = (j == 4) || (j == 16);
         n_tests++;
         if ({y3, ch3, vld3, wrap3} !== {e, e, 1'b1, w}) begin
            $display("FAIL np2_scan j%0d: got %b want %b", j, {y3, ch3, vld3, wrap3},
                     {e, e, 1'b1, w});
            n_fail++;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; din = 8'b11_10_01_00; s = '0; en = 1'b0; mode = 1'b0;
      din3 = 6'b10_01_00; s3 = '0; en3 = 1'b0; mode3 = 1'b0;
      test_reset();
      test_manual();
      test_scan();
      test_live();
      test_mode_switch();
      test_idle_resume();
      test_non_pow2();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
